sa_tile_sequencer: RTL
======================

// Module: sa_tile_sequencer
// PURPOSE
//  Producer/consumer counterpart of the N x N weight-stationary systolic array.
//  Per tile, it accepts N weight rows and then a stream of activation vectors, driving the
//  array's en/clear_acc/load_weight/load_row/weight_vector/act_vector pins.
//  After the stream it drains the array, captures result_vector, and returns it row by row
//  on a valid/ready stream. Sits between the on-chip buffers and the array.
// PARAMETERS
//  N          8     array dimension (rows = cols)
//  DATA_W     8     activation/weight width (signed INT8)
//  ACC_W      32    accumulator/result width
//  ARRAY_LAT  16    drain cycles after last activation (>=1; default 2*N)
// PORTS
//  clk              in   1            clock
//  rst              in   1            synchronous, active-low reset
//  start            in   1            begin tile; sampled only in IDLE
//  busy             out  1            high in every state except IDLE
//  done             out  1            1-cycle pulse after last result row handshake
//  w_valid/w_ready  in/out 1          weight-row stream handshake
//  w_data           in   N*DATA_W     weight row, row index = acceptance order 0..N-1
//  a_valid/a_ready  in/out 1          activation stream handshake
//  a_data           in   N*DATA_W     activation vector
//  a_last           in   1            marks final activation vector of tile
//  sa_en            out  1            array enable
//  sa_clear_acc     out  1            array accumulator clear
//  sa_load_weight   out  1            array weight-load strobe
//  sa_load_row      out  $clog2(N)    array row select
//  sa_weight_vector out  N*DATA_W     array weight bus
//  sa_act_vector    out  N*DATA_W     array activation bus
//  sa_result_vector in   N*N*ACC_W    array result (post-ReLU), PE (i,j) at [(i*N+j)*ACC_W +: ACC_W]
//  r_valid/r_ready  out/in 1          result stream handshake
//  r_data           out  N*ACC_W      one result row (PEs i*N .. i*N+N-1)
//  r_row            out  $clog2(N)    row index of r_data
//  r_last           out  1            high with r_valid on row N-1
//  stall_cnt        out  32           STREAM cycles with a_valid=0 (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; every output 0; counters 0; capture regs 0.
//  Reset mid-tile aborts immediately with the same values; no done pulse.
//  FSM: IDLE -> CLEAR -> LOAD_W -> STREAM -> DRAIN -> CAPTURE -> OUTPUT -> IDLE.
//  IDLE: start=1 -> CLEAR next cycle; start ignored in all other states.
//  CLEAR: exactly 1 cycle, sa_clear_acc=1, sa_en=1, then LOAD_W.
//  LOAD_W: w_ready=1, sa_en=0.
//    On each w handshake: sa_load_weight=1 and sa_load_row=row_cnt in the same cycle
//    (combinational pass-through); sa_weight_vector=w_data.
//    Advance after N handshakes; no handshake -> load_weight=0.
//  STREAM: a_ready=1.
//    a handshake: sa_en=1, sa_act_vector=a_data.
//    a_valid=0: sa_en=0 (array frozen), act=0.
//    Handshake with a_last=1 -> DRAIN; a_last on the first vector is legal.
//  DRAIN: sa_en=1, sa_act_vector=0 for exactly ARRAY_LAT cycles, then CAPTURE.
//  CAPTURE: 1 cycle; register sa_result_vector; sa_en=0.
//  OUTPUT: r_valid=1, r_row=row_cnt, r_data=captured row; all stable while r_ready=0.
//    Handshake increments the row; handshake on row N-1 (r_last=1) -> IDLE, done=1 that next cycle.
//  w_ready/a_ready/r_valid are 0 outside their state; sa_* outputs are 0 unless stated.
//  Row counters are $clog2(N) bits, clear on state entry, never wrap within a state.
//  No arithmetic on data; results pass through unmodified.
// CONFIGURATION
//  SA_SEQ_STALL_CNT_EN defined:
//    stall_cnt counts STREAM cycles with a_valid=0; saturates at 2^32-1;
//    cleared on CLEAR entry; held through IDLE.
//  Undefined: stall_cnt tied to 0, no counter logic.
// STRUCTURE
//  sa_pkg: state localparams (IDLE..OUTPUT, 3-bit), ROW_W=$clog2(N) helper.
//  Sub-module sa_result_capture: N*N*ACC_W capture register plus row mux for r_data/r_row/r_last.
//  The FSM, counters and handshakes stay in the top level.
// TESTING (N=4, ARRAY_LAT=8)
//  1. Reset mid-STREAM:
//     rst=0 for 1 cycle -> next cycle busy=0, all sa_*=0, r_valid=0; following start runs clean.
//  2. Weight load:
//     4 w rows 0x01..0x04 with w_valid gaps -> load_weight pulses exactly on handshakes,
//     load_row 0,1,2,3, then a_ready=1.
//  3. Identity weights, activations {1,2,3,4} (single vector, a_last=1) ->
//     8 drain cycles with en=1, act=0; results match the array model.
//  4. a_valid toggling 1,0,0,1 in STREAM ->
//     sa_en follows handshakes only; stall_cnt=2 with SA_SEQ_STALL_CNT_EN, 0 without.
//  5. r_ready held 0 for 5 cycles on row 1 -> r_data/r_row stable;
//     rows 0..3 in order; r_last only on row 3; done 1 cycle after.
//  6. start asserted while busy -> ignored; tile completes with exactly one done pulse.

Source files
------------

// File: rtl/sa_tile_sequencer_pkg.sv
// Shared types for the systolic-array tile sequencer: FSM state encoding and
// the row/counter width helper.
package sa_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD_W  = 3'd2,
        S_STREAM  = 3'd3,
        S_DRAIN   = 3'd4,
        S_CAPTURE = 3'd5,
        S_OUTPUT  = 3'd6
    } seq_state_e;

    // $clog2 with a floor of 1 so single-entry counters still get a bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_tile_sequencer_capture.sv
// Result capture register for the whole array plus the row mux that feeds the
// result stream; outputs read zero whenever the stream is not valid.
module sa_result_capture
    import sa_tile_sequencer_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned ROW_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en_i,
    input  logic [N*N*ACC_W-1:0]   result_vec_i,
    input  logic                   valid_i,
    input  logic [ROW_W-1:0]       row_sel_i,
    output logic [N*ACC_W-1:0]     r_data_o,
    output logic [ROW_W-1:0]       r_row_o,
    output logic                   r_last_o
);

    logic [N*N*ACC_W-1:0] cap_q;
    logic [N*ACC_W-1:0]   row_view [N];

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_q <= '0;
        end else if (cap_en_i) begin
            cap_q <= result_vec_i;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_row
        assign row_view[g] = cap_q[g*N*ACC_W +: N*ACC_W];
    end

    always_comb begin
        r_data_o = '0;
        r_row_o  = '0;
        r_last_o = 1'b0;
        if (valid_i) begin
            r_data_o = row_view[row_sel_i];
            r_row_o  = row_sel_i;
            r_last_o = (row_sel_i == ROW_W'(N - 1));
        end
    end

endmodule

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for the N x N weight-stationary systolic array: loads weights,
// streams activations, drains, captures and returns results row by row.
// Optional stall counter enabled by defining SA_SEQ_STALL_CNT_EN.
module sa_tile_sequencer
    import sa_tile_sequencer_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned ARRAY_LAT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [N*DATA_W-1:0]          w_data,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [N*DATA_W-1:0]          a_data,
    input  logic                         a_last,
    output logic                         sa_en,
    output logic                         sa_clear_acc,
    output logic                         sa_load_weight,
    output logic [clog2_min1(N)-1:0]     sa_load_row,
    output logic [N*DATA_W-1:0]          sa_weight_vector,
    output logic [N*DATA_W-1:0]          sa_act_vector,
    input  logic [N*N*ACC_W-1:0]         sa_result_vector,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [N*ACC_W-1:0]           r_data,
    output logic [clog2_min1(N)-1:0]     r_row,
    output logic                         r_last,
    output logic [31:0]                  stall_cnt
);

    localparam int unsigned ROW_W = clog2_min1(N);
    localparam int unsigned DRN_W = clog2_min1(ARRAY_LAT);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(ARRAY_LAT - 1);

    seq_state_e       state_q;
    logic [ROW_W-1:0] row_q;
    logic [DRN_W-1:0] drain_q;
    logic             busy_q, done_q, clear_q;
    logic             w_ready_q, a_ready_q, r_valid_q;
    logic             w_hs, a_hs;

    // Handshake flags are set on the transition into their state so they are
    // already high on the first cycle of that state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clear_q   <= 1'b0;
            w_ready_q <= 1'b0;
            a_ready_q <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                        clear_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_LOAD_W;
                    w_ready_q <= 1'b1;
                    row_q     <= '0;
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        if (row_q == ROW_LAST) begin
                            state_q   <= S_STREAM;
                            w_ready_q <= 1'b0;
                            a_ready_q <= 1'b1;
                            row_q     <= '0;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (a_valid && a_last) begin
                        state_q   <= S_DRAIN;
                        a_ready_q <= 1'b0;
                        drain_q   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRN_LAST) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state_q   <= S_OUTPUT;
                    r_valid_q <= 1'b1;
                    row_q     <= '0;
                end
                S_OUTPUT: begin
                    if (r_ready) begin
                        if (row_q == ROW_LAST) begin
                            state_q   <= S_IDLE;
                            r_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign w_hs = w_ready_q && w_valid;
    assign a_hs = a_ready_q && a_valid;

    // Array strobes follow the live handshake within the same cycle
    always_comb begin
        sa_en            = clear_q || a_hs || (state_q == S_DRAIN);
        sa_clear_acc     = clear_q;
        sa_load_weight   = w_hs;
        sa_load_row      = w_hs ? row_q  : '0;
        sa_weight_vector = w_hs ? w_data : '0;
        sa_act_vector    = a_hs ? a_data : '0;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign w_ready = w_ready_q;
    assign a_ready = a_ready_q;
    assign r_valid = r_valid_q;

    sa_result_capture #(
        .N     (N),
        .ACC_W (ACC_W),
        .ROW_W (ROW_W)
    ) u_capture (
        .clk          (clk),
        .rst          (rst),
        .cap_en_i     (state_q == S_CAPTURE),
        .result_vec_i (sa_result_vector),
        .valid_i      (r_valid_q),
        .row_sel_i    (row_q),
        .r_data_o     (r_data),
        .r_row_o      (r_row),
        .r_last_o     (r_last)
    );

`ifdef SA_SEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (a_ready_q && !a_valid && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
